// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan display.
// Holds the active-low glyphs ({A,B,C,D,E,F,G} with A at bit 6), the blank
// pattern, and hex_to_seg, which turns a 4-bit value into its glyph.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Lower-case b and d keep 8 and B, and 0 and D, distinguishable.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] glyph;
        case (hex)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational hex-to-glyph decoder.
// Ports:
//   hex  in   4-bit value
//   seg  out  active-low cathode pattern {A..G}, A at seg[6]
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment controller.
// A bank of NUM_DIGITS hex registers is written by index. The common anodes
// are scanned on their own, one slot of REFRESH_DIV cycles per digit. The
// first cycle of every slot is blanked so the previous digit does not ghost
// onto the next anode. The pin outputs are registered.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous reset, active low
//   num    in   hex value to store
//   sel    in   digit index for the write
//   write  in   store num into digit sel
//   clear  in   mark all digits blank (values are kept)
//   an     out  anode enables, active low, one-hot while lit
//   seg    out  cathodes, active low, {A..G} with A at seg[6]
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            num,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  write,
    input  logic                  clear,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic [3:0]            value_q [NUM_DIGITS];
    logic [3:0]            value_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [6:0]            glyph;

    // One decoder serves every digit: only the digit under the pointer is shown.
    seg_decoder u_decoder (
        .hex (value_q[ptr_q]),
        .seg (glyph)
    );

    // Scan timing. The slot counter runs freely. The pointer moves on to the
    // next digit each time the counter wraps.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        ptr_d = ptr_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (ptr_q == SEL_W'(NUM_DIGITS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + SEL_W'(1);
            end
        end
    end

    // Digit storage. Clear is applied before write, so a write on the same
    // edge leaves exactly one valid digit. An index past the last digit is
    // dropped.
    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end
        if (write && (int'(sel) < NUM_DIGITS)) begin
            value_d[sel] = num;
            valid_d[sel] = 1'b1;
        end
    end

    // Next pin state. Cycle 0 of each slot is the ghost guard. After that,
    // the selected anode is pulled low and the digit's glyph is driven, or the
    // cathodes stay blank if the digit is invalid.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (cnt_q != '0) begin
            an_d  = ~(NUM_DIGITS'(1) << ptr_q);
            seg_d = valid_q[ptr_q] ? glyph : SEG_BLANK;
        end
    end

    // All state is held here. Reset turns every pin off at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            value_q <= '{default: '0};
            valid_q <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            value_q <= value_d;
            valid_q <= valid_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: self-checking bench for seg_scan_display.
// Two instances run side by side on the same stimulus: an 8-digit display and
// a 6-digit display, both with REFRESH_DIV=4. A behavioural model predicts the
// pins for each edge and queues them. The tests pop the predictions and
// compare them against the DUT pins.
module tb_seg_scan_display;

    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] num   = '0;
    logic [2:0] sel   = '0;
    logic       write = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] an8;
    logic [6:0] seg8;
    logic [5:0] an6;
    logic [6:0] seg6;

    int checks   = 0;
    int failures = 0;

    seg_scan_display #(.NUM_DIGITS(8), .REFRESH_DIV(DIV)) dut8 (
        .clk(clk), .reset(reset), .num(num), .sel(sel),
        .write(write), .clear(clear), .an(an8), .seg(seg8)
    );

    seg_scan_display #(.NUM_DIGITS(6), .REFRESH_DIV(DIV)) dut6 (
        .clk(clk), .reset(reset), .num(num), .sel(sel),
        .write(write), .clear(clear), .an(an6), .seg(seg6)
    );

    always #5 clk = ~clk;

    logic [6:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    // Model state. t8/t6 count the edges since reset was released. The pins
    // shown after edge e reflect time t=e-1, so cnt=t%DIV and ptr=(t/DIV)%N.
    int         t8, t6;
    logic [3:0] m8_val [8];
    logic [3:0] m6_val [6];
    logic [7:0] m8_valid;
    logic [5:0] m6_valid;
    logic [14:0] q8 [$];
    logic [12:0] q6 [$];
    logic [7:0] ea8;
    logic [5:0] ea6;
    logic [6:0] es8, es6;
    int         c8, p8, c6, p6;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t8 = 0; t6 = 0; m8_valid = '0; m6_valid = '0;
            for (int i = 0; i < 8; i++) m8_val[i] = '0;
            for (int i = 0; i < 6; i++) m6_val[i] = '0;
        end else begin
            c8 = t8 % DIV; p8 = (t8 / DIV) % 8;
            c6 = t6 % DIV; p6 = (t6 / DIV) % 6;
            ea8 = 8'hFF; es8 = BLANK;
            ea6 = 6'h3F; es6 = BLANK;
            if (c8 != 0) begin
                ea8[p8] = 1'b0;
                if (m8_valid[p8]) es8 = FONT[m8_val[p8]];
            end
            if (c6 != 0) begin
                ea6[p6] = 1'b0;
                if (m6_valid[p6]) es6 = FONT[m6_val[p6]];
            end
            q8.push_back({ea8, es8});
            q6.push_back({ea6, es6});
            t8++; t6++;
            if (clear) begin m8_valid = '0; m6_valid = '0; end
            if (write) begin
                m8_val[sel] = num; m8_valid[sel] = 1'b1;
                if (sel < 3'd6) begin m6_val[sel] = num; m6_valid[sel] = 1'b1; end
            end
        end
    end

    task automatic drive_write(input logic [2:0] s, input logic [3:0] n);
        @(negedge clk);
        sel = s; num = n; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] e8;
        logic [12:0] e6;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an8 !== 8'hFF || seg8 !== BLANK) begin
            failures++;
            $display("[TB] FAIL reset_hold8: an=%h seg=%b required an=ff seg=1111111", an8, seg8);
        end
        checks++;
        if (an6 !== 6'h3F || seg6 !== BLANK) begin
            failures++;
            $display("[TB] FAIL reset_hold6: an=%h seg=%b required an=3f seg=1111111", an6, seg6);
        end
        reset = 1'b1;
        @(negedge clk);
        q8.delete(); q6.delete();
        repeat (2 * 8 * DIV) begin
            @(negedge clk);
            checks++;
            if (q8.size() == 0) begin
                failures++; $display("[TB] FAIL reset_scan8: no prediction queued");
            end else begin
                e8 = q8.pop_front();
                if ({an8, seg8} !== e8) begin
                    failures++;
                    $display("[TB] FAIL reset_scan8: an=%h seg=%b required an=%h seg=%b", an8, seg8, e8[14:7], e8[6:0]);
                end
            end
            checks++;
            if (q6.size() == 0) begin
                failures++; $display("[TB] FAIL reset_scan6: no prediction queued");
            end else begin
                e6 = q6.pop_front();
                if ({an6, seg6} !== e6) begin
                    failures++;
                    $display("[TB] FAIL reset_scan6: an=%h seg=%b required an=%h seg=%b", an6, seg6, e6[12:7], e6[6:0]);
                end
            end
        end
    endtask

    task automatic test_write_all();
        logic [14:0] e8;
        logic [12:0] e6;
        for (int i = 0; i < 8; i++) drive_write(3'(i), 4'(i));
        @(negedge clk);
        q8.delete(); q6.delete();
        repeat (2 * 8 * DIV) begin
            @(negedge clk);
            checks++;
            if (q8.size() == 0) begin
                failures++; $display("[TB] FAIL write_all8: no prediction queued");
            end else begin
                e8 = q8.pop_front();
                if ({an8, seg8} !== e8) begin
                    failures++;
                    $display("[TB] FAIL write_all8: an=%h seg=%b required an=%h seg=%b", an8, seg8, e8[14:7], e8[6:0]);
                end
            end
            checks++;
            if (q6.size() == 0) begin
                failures++; $display("[TB] FAIL write_all6: no prediction queued");
            end else begin
                e6 = q6.pop_front();
                if ({an6, seg6} !== e6) begin
                    failures++;
                    $display("[TB] FAIL write_all6: an=%h seg=%b required an=%h seg=%b", an6, seg6, e6[12:7], e6[6:0]);
                end
            end
        end
    endtask

    task automatic test_live_update();
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (((t8 - 1) % DIV) == 1 && (((t8 - 1) / DIV) % 8) == 3) found = 1;
        end
        checks++;
        if (!found || an8 !== 8'hF7 || seg8 !== 7'b0000110) begin
            failures++;
            $display("[TB] FAIL live_before: an=%h seg=%b required an=f7 seg=0000110", an8, seg8);
        end
        sel = 3'd3; num = 4'hF; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        checks++;
        if (seg8 !== 7'b0000110) begin
            failures++;
            $display("[TB] FAIL live_at_edge: seg=%b required 0000110", seg8);
        end
        @(negedge clk);
        checks++;
        if (an8 !== 8'hF7 || seg8 !== 7'b0111000) begin
            failures++;
            $display("[TB] FAIL live_after: an=%h seg=%b required an=f7 seg=0111000", an8, seg8);
        end
    endtask

    task automatic test_clear_write();
        logic [14:0] e8;
        logic [12:0] e6;
        @(negedge clk);
        clear = 1'b1; write = 1'b1; sel = 3'd5; num = 4'h8;
        @(negedge clk);
        clear = 1'b0; write = 1'b0;
        @(negedge clk);
        q8.delete(); q6.delete();
        repeat (2 * 8 * DIV) begin
            @(negedge clk);
            checks++;
            if (q8.size() == 0) begin
                failures++; $display("[TB] FAIL clear_write8: no prediction queued");
            end else begin
                e8 = q8.pop_front();
                if ({an8, seg8} !== e8) begin
                    failures++;
                    $display("[TB] FAIL clear_write8: an=%h seg=%b required an=%h seg=%b", an8, seg8, e8[14:7], e8[6:0]);
                end
            end
            checks++;
            if (q6.size() == 0) begin
                failures++; $display("[TB] FAIL clear_write6: no prediction queued");
            end else begin
                e6 = q6.pop_front();
                if ({an6, seg6} !== e6) begin
                    failures++;
                    $display("[TB] FAIL clear_write6: an=%h seg=%b required an=%h seg=%b", an6, seg6, e6[12:7], e6[6:0]);
                end
            end
            if (an8 == 8'hDF) begin
                checks++;
                if (seg8 !== 7'b0000000) begin
                    failures++;
                    $display("[TB] FAIL clear_write_slot5: seg=%b required 0000000", seg8);
                end
            end
        end
    endtask

    task automatic test_bad_sel();
        logic [12:0] e6;
        bit prev, found;
        int n;
        drive_write(3'd7, 4'h3);
        drive_write(3'd6, 4'h9);
        @(negedge clk);
        q8.delete(); q6.delete();
        repeat (2 * 6 * DIV) begin
            @(negedge clk);
            checks++;
            if (q6.size() == 0) begin
                failures++; $display("[TB] FAIL bad_sel6: no prediction queued");
            end else begin
                e6 = q6.pop_front();
                if ({an6, seg6} !== e6) begin
                    failures++;
                    $display("[TB] FAIL bad_sel6: an=%h seg=%b required an=%h seg=%b", an6, seg6, e6[12:7], e6[6:0]);
                end
            end
        end
        // Measure the frame length as the distance between two onsets of digit 0.
        prev = 1; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (an6 === 6'h3E && !prev) found = 1;
            prev = (an6 === 6'h3E);
        end
        n = 0; prev = 1; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            n++;
            if (an6 === 6'h3E && !prev) found = 1;
            prev = (an6 === 6'h3E);
        end
        checks++;
        if (!found || n != 6 * DIV) begin
            failures++;
            $display("[TB] FAIL frame6: cycles=%0d required %0d", n, 6 * DIV);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] e8;
        drive_write(3'd0, 4'hA);
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (an8 !== 8'hFF || seg8 !== BLANK || an6 !== 6'h3F || seg6 !== BLANK) begin
            failures++;
            $display("[TB] FAIL reset_async: an8=%h seg8=%b an6=%h seg6=%b required all ones", an8, seg8, an6, seg6);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (an8 !== 8'hFF || seg8 !== BLANK) begin
            failures++;
            $display("[TB] FAIL restart_guard: an=%h seg=%b required an=ff seg=1111111", an8, seg8);
        end
        @(negedge clk);
        checks++;
        if (an8 !== 8'hFE || seg8 !== BLANK) begin
            failures++;
            $display("[TB] FAIL restart_digit0: an=%h seg=%b required an=fe seg=1111111", an8, seg8);
        end
        q8.delete(); q6.delete();
        repeat (8 * DIV) begin
            @(negedge clk);
            checks++;
            if (q8.size() == 0) begin
                failures++; $display("[TB] FAIL restart_scan8: no prediction queued");
            end else begin
                e8 = q8.pop_front();
                if ({an8, seg8} !== e8 || seg8 !== BLANK) begin
                    failures++;
                    $display("[TB] FAIL restart_scan8: an=%h seg=%b required an=%h seg=%b", an8, seg8, e8[14:7], e8[6:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_live_update();
        test_clear_write();
        test_bad_sel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
